// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared opcodes, ALUOp classes, FSM states and control bundle for the RV32I control path
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_IMM    = 2'b11;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       pc_source;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// rtl/pipelined_control_unit_if.sv - ID-side inputs and staged control outputs; ForwardA/B exist only with CTRL_FWD_EN
interface pipelined_control_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2
);
  logic                  id_valid;
  logic [6:0]            Opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [REG_ADDR_W-1:0] rd;
  logic                  BranchTaken;

  logic ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg;
  logic ex_ALUSrc, ex_Branch, ex_Jump, ex_PCSource;
  logic [ALUOP_W-1:0]    ex_ALUOp;
  logic [2:0]            ex_funct3;
  logic [6:0]            ex_funct7;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic mem_RegWrite, mem_MemRead, mem_MemWrite, mem_MemtoReg;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic wb_RegWrite, wb_MemtoReg;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic Stall, FlushIFID, IllegalInstr;
`ifdef CTRL_FWD_EN
  logic [1:0] ForwardA, ForwardB;
`endif

  modport master (
    output id_valid, Opcode, funct3, funct7, rs1, rs2, rd, BranchTaken,
`ifdef CTRL_FWD_EN
    input  ForwardA, ForwardB,
`endif
    input  ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch,
           ex_Jump, ex_PCSource, ex_ALUOp, ex_funct3, ex_funct7, ex_rd,
           mem_RegWrite, mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_rd,
           wb_RegWrite, wb_MemtoReg, wb_rd, Stall, FlushIFID, IllegalInstr
  );

  modport slave (
    input  id_valid, Opcode, funct3, funct7, rs1, rs2, rd, BranchTaken,
`ifdef CTRL_FWD_EN
    output ForwardA, ForwardB,
`endif
    output ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_Branch,
           ex_Jump, ex_PCSource, ex_ALUOp, ex_funct3, ex_funct7, ex_rd,
           mem_RegWrite, mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_rd,
           wb_RegWrite, wb_MemtoReg, wb_rd, Stall, FlushIFID, IllegalInstr
  );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to control-bundle decode with source-use flags
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       rs1_used,
  output logic       rs2_used,
  output logic       illegal
);

  // Unknown opcodes decode to an all-zero bundle so they behave like a bubble downstream
  always_comb begin
    ctrl     = '0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_RTYPE;
        rs2_used       = 1'b1;
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        rs2_used       = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_BRANCH;
        rs2_used    = 1'b1;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.pc_source = 1'b1;
        rs1_used       = 1'b0;
      end
      OP_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.pc_source = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_IMM;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        rs1_used       = 1'b0;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - RV32I control path: decode, ID/EX/MEM/WB control stages, hazard FSM; option macro CTRL_FWD_EN
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int ALUOP_W        = 2,
  parameter int LOAD_USE_STALL = 1
) (
  input logic                      clk,
  input logic                      rst_n,
  pipelined_control_unit_if.slave  bus
);

  localparam logic [1:0] LU_RELOAD = 2'(LOAD_USE_STALL - 1);

  ctrl_t id_ctrl;
  logic  rs1_used, rs2_used, id_illegal;

  ctrl_decode u_decode (
    .opcode   (bus.Opcode),
    .ctrl     (id_ctrl),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .illegal  (id_illegal)
  );

  state_t                state, state_nxt;
  logic [1:0]            cnt, cnt_nxt;
  logic                  stall, bubble;
  ctrl_t                 ex_ctrl;
  logic [2:0]            ex_funct3_q;
  logic [6:0]            ex_funct7_q;
  logic [REG_ADDR_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic                  mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic                  wb_reg_write, wb_mem_to_reg, illegal_q;
  logic                  rs1_live, rs2_live, hit_ex, lu_hazard, raw_hazard;

  // Index 0 is hard-wired zero, so it never depends on a producer
  assign rs1_live  = rs1_used && (bus.rs1 != '0);
  assign rs2_live  = rs2_used && (bus.rs2 != '0);
  assign hit_ex    = (rs1_live && (bus.rs1 == ex_rd_q)) || (rs2_live && (bus.rs2 == ex_rd_q));
  assign lu_hazard = ex_ctrl.mem_read && (ex_rd_q != '0) && hit_ex;

`ifdef CTRL_FWD_EN
  assign raw_hazard = 1'b0;
`else
  logic hit_mem;
  assign hit_mem    = (rs1_live && (bus.rs1 == mem_rd_q)) || (rs2_live && (bus.rs2 == mem_rd_q));
  assign raw_hazard = (ex_ctrl.reg_write && hit_ex) || (mem_reg_write && hit_mem);
`endif

  // Hazard sequencing: a taken redirect beats any stall and cancels a pending load-use sequence
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    bubble    = !bus.id_valid;
    case (state)
      RUN: begin
        if (bus.BranchTaken) begin
          bubble  = 1'b1;
          cnt_nxt = '0;
        end else if (bus.id_valid && lu_hazard) begin
          stall     = 1'b1;
          bubble    = 1'b1;
          cnt_nxt   = LU_RELOAD;
          state_nxt = (LOAD_USE_STALL > 1) ? STALL : RUN;
        end else if (bus.id_valid && raw_hazard) begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
      end
      STALL: begin
        if (bus.BranchTaken) begin
          bubble    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end else begin
          stall   = 1'b1;
          bubble  = 1'b1;
          cnt_nxt = cnt - 2'd1;
          if (cnt == 2'd1) state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // FSM state and ID/EX -> EX/MEM -> MEM/WB control shift; bubbles load all-zero ID/EX
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= RUN;
      cnt            <= '0;
      ex_ctrl        <= '0;
      ex_funct3_q    <= '0;
      ex_funct7_q    <= '0;
      ex_rd_q        <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_rd_q       <= '0;
      wb_reg_write   <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_rd_q        <= '0;
      illegal_q      <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      ex_ctrl        <= bubble ? '0 : id_ctrl;
      ex_funct3_q    <= bubble ? '0 : bus.funct3;
      ex_funct7_q    <= bubble ? '0 : bus.funct7;
      ex_rd_q        <= bubble ? '0 : bus.rd;
      mem_reg_write  <= ex_ctrl.reg_write;
      mem_mem_read   <= ex_ctrl.mem_read;
      mem_mem_write  <= ex_ctrl.mem_write;
      mem_mem_to_reg <= ex_ctrl.mem_to_reg;
      mem_rd_q       <= ex_rd_q;
      wb_reg_write   <= mem_reg_write;
      wb_mem_to_reg  <= mem_mem_to_reg;
      wb_rd_q        <= mem_rd_q;
      illegal_q      <= bus.id_valid && id_illegal;
    end
  end

`ifdef CTRL_FWD_EN
  logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs2_q;

  // Only sources the EX instruction actually reads are kept, so unused fields never forward
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
    end else begin
      ex_rs1_q <= (bubble || !rs1_used) ? '0 : bus.rs1;
      ex_rs2_q <= (bubble || !rs2_used) ? '0 : bus.rs2;
    end
  end

  assign bus.ForwardA = (mem_reg_write && (ex_rs1_q != '0) && (mem_rd_q == ex_rs1_q)) ? 2'b10 :
                        (wb_reg_write  && (ex_rs1_q != '0) && (wb_rd_q  == ex_rs1_q)) ? 2'b01 : 2'b00;
  assign bus.ForwardB = (mem_reg_write && (ex_rs2_q != '0) && (mem_rd_q == ex_rs2_q)) ? 2'b10 :
                        (wb_reg_write  && (ex_rs2_q != '0) && (wb_rd_q  == ex_rs2_q)) ? 2'b01 : 2'b00;
`endif

  assign bus.ex_RegWrite  = ex_ctrl.reg_write;
  assign bus.ex_MemRead   = ex_ctrl.mem_read;
  assign bus.ex_MemWrite  = ex_ctrl.mem_write;
  assign bus.ex_MemtoReg  = ex_ctrl.mem_to_reg;
  assign bus.ex_ALUSrc    = ex_ctrl.alu_src;
  assign bus.ex_Branch    = ex_ctrl.branch;
  assign bus.ex_Jump      = ex_ctrl.jump;
  assign bus.ex_PCSource  = ex_ctrl.pc_source;
  assign bus.ex_ALUOp     = ALUOP_W'(ex_ctrl.alu_op);
  assign bus.ex_funct3    = ex_funct3_q;
  assign bus.ex_funct7    = ex_funct7_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.mem_RegWrite = mem_reg_write;
  assign bus.mem_MemRead  = mem_mem_read;
  assign bus.mem_MemWrite = mem_mem_write;
  assign bus.mem_MemtoReg = mem_mem_to_reg;
  assign bus.mem_rd       = mem_rd_q;
  assign bus.wb_RegWrite  = wb_reg_write;
  assign bus.wb_MemtoReg  = wb_mem_to_reg;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.Stall        = stall;
  assign bus.FlushIFID    = bus.BranchTaken;
  assign bus.IllegalInstr = illegal_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - randomized and directed checks of pipelined_control_unit against an instruction-level model
module tb_pipelined_control_unit;

  localparam int RW  = 5;
  localparam int AW  = 2;
  localparam int LUS = 3;
`ifdef CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [6:0] T_R = 7'b0110011, T_LD = 7'b0000011, T_ST = 7'b0100011, T_BR = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111, T_JALR = 7'b1100111, T_IMM = 7'b0010011, T_LUI = 7'b0110111;

  typedef struct packed {
    logic       v;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_control_unit_if #(.REG_ADDR_W(RW), .ALUOP_W(AW)) bus ();

  pipelined_control_unit #(.REG_ADDR_W(RW), .ALUOP_W(AW), .LOAD_USE_STALL(LUS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  ins_t m_ex, m_mem, m_wb;
  int   m_left;
  logic m_ill;
  logic obs_stall, obs_flush;
  logic [6:0] op_tbl [8];
  logic [1:0] alu_tbl [8];
  logic       rw_tbl [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch,Jump,PCSource,ALUOp}
  function automatic logic [9:0] ref_ctrl(input logic [6:0] op);
    case (op)
      T_R:     return 10'b1000_0000_10;
      T_LD:    return 10'b1101_1000_00;
      T_ST:    return 10'b0010_1000_00;
      T_BR:    return 10'b0000_0100_01;
      T_JAL:   return 10'b1000_0011_00;
      T_JALR:  return 10'b1000_1011_00;
      T_IMM:   return 10'b1000_1000_11;
      T_LUI:   return 10'b1000_1000_00;
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic uses1(input logic [6:0] op);
    return !(op == T_JAL || op == T_LUI);
  endfunction

  function automatic logic uses2(input logic [6:0] op);
    return (op == T_R || op == T_ST || op == T_BR);
  endfunction

  function automatic logic writes(input ins_t i);
    logic [9:0] c;
    c = ref_ctrl(i.op);
    return i.v && c[9];
  endfunction

  function automatic logic reads_reg(input ins_t i, input logic [4:0] r);
    return (r != 5'd0) && ((uses1(i.op) && i.rs1 == r) || (uses2(i.op) && i.rs2 == r));
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] src, input logic used);
    if (!m_ex.v || !used || src == 5'd0) return 2'b00;
    if (writes(m_mem) && m_mem.rd == src) return 2'b10;
    if (writes(m_wb) && m_wb.rd == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_outputs();
    logic [9:0] c;
    c = m_ex.v ? ref_ctrl(m_ex.op) : 10'd0;
    check("ex_ctrl", {bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_MemtoReg, bus.ex_ALUSrc,
                      bus.ex_Branch, bus.ex_Jump, bus.ex_PCSource, bus.ex_ALUOp}, c);
    check("ex_rd", bus.ex_rd, m_ex.v ? m_ex.rd : 5'd0);
    if (m_ex.v) begin
      check("ex_funct3", bus.ex_funct3, m_ex.f3);
      check("ex_funct7", bus.ex_funct7, m_ex.f7);
    end
    c = m_mem.v ? ref_ctrl(m_mem.op) : 10'd0;
    check("mem_ctrl", {bus.mem_RegWrite, bus.mem_MemRead, bus.mem_MemWrite, bus.mem_MemtoReg}, c[9:6]);
    check("mem_rd", bus.mem_rd, m_mem.v ? m_mem.rd : 5'd0);
    c = m_wb.v ? ref_ctrl(m_wb.op) : 10'd0;
    check("wb_ctrl", {bus.wb_RegWrite, bus.wb_MemtoReg}, {c[9], c[6]});
    check("wb_rd", bus.wb_rd, m_wb.v ? m_wb.rd : 5'd0);
    check("illegal", bus.IllegalInstr, m_ill);
`ifdef CTRL_FWD_EN
    check("fwd_a", bus.ForwardA, ref_fwd(m_ex.rs1, uses1(m_ex.op)));
    check("fwd_b", bus.ForwardB, ref_fwd(m_ex.rs2, uses2(m_ex.op)));
`endif
  endtask

  // One clock: drive ID inputs, check combinational outputs, advance model, check registered outputs
  task automatic step(input logic rst, input logic v, input logic [6:0] op, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [4:0] d, input logic bt);
    ins_t cur;
    logic exp_stall, issue;
    int   left_n;
    cur.v = v; cur.op = op; cur.f3 = 3'($urandom); cur.f7 = 7'($urandom);
    cur.rd = d; cur.rs1 = s1; cur.rs2 = s2;
    rst_n = rst;
    bus.id_valid = v; bus.Opcode = op; bus.funct3 = cur.f3; bus.funct7 = cur.f7;
    bus.rs1 = s1; bus.rs2 = s2; bus.rd = d; bus.BranchTaken = bt;
    #1;
    exp_stall = 1'b0;
    issue     = v;
    left_n    = m_left;
    if (bt) begin
      issue = 1'b0; left_n = 0;
    end else if (m_left > 0) begin
      exp_stall = 1'b1; issue = 1'b0; left_n = m_left - 1;
    end else if (v && m_ex.v && m_ex.op == T_LD && reads_reg(cur, m_ex.rd)) begin
      exp_stall = 1'b1; issue = 1'b0; left_n = LUS - 1;
    end else if (v && !FWD && ((writes(m_ex) && reads_reg(cur, m_ex.rd)) ||
                               (writes(m_mem) && reads_reg(cur, m_mem.rd)))) begin
      exp_stall = 1'b1; issue = 1'b0;
    end
    obs_stall = bus.Stall;
    obs_flush = bus.FlushIFID;
    if (rst) begin
      check("stall", obs_stall, exp_stall);
      check("flush", obs_flush, bt);
    end
    @(posedge clk);
    if (!rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_left = 0; m_ill = 1'b0;
    end else begin
      m_wb   = m_mem;
      m_mem  = m_ex;
      m_ex   = issue ? cur : '0;
      m_left = left_n;
      m_ill  = v && (ref_ctrl(op) == 10'd0);
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drain();
    repeat (3) step(1'b1, 1'b0, T_R, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, guard, exp_n;
    m_ex = '0; m_mem = '0; m_wb = '0; m_left = 0; m_ill = 1'b0;
    op_tbl  = '{T_R, T_LD, T_ST, T_BR, T_JAL, T_IMM, T_JALR, T_LUI};
    alu_tbl = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00};
    rw_tbl  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset hold with an R-type presented
    repeat (2) step(1'b0, 1'b1, T_R, 5'd1, 5'd2, 5'd3, 1'b0);
    check("rst_stall", bus.Stall, 1'b0);
    check("rst_outs", {bus.ex_RegWrite, bus.ex_ALUOp, bus.ex_rd, bus.mem_RegWrite, bus.mem_rd,
                       bus.wb_RegWrite, bus.wb_rd, bus.IllegalInstr}, 32'd0);

    // Opcode sequence: ALUOp one cycle later, wb_RegWrite three cycles later
    for (int k = 0; k < 10; k++) begin
      if (k < 8) step(1'b1, 1'b1, op_tbl[k], 5'd0, 5'd0, 5'(k + 1), 1'b0);
      else       step(1'b1, 1'b0, T_R, 5'd0, 5'd0, 5'd0, 1'b0);
      if (k < 8)  check("seq_aluop", bus.ex_ALUOp, alu_tbl[k]);
      if (k >= 2) check("seq_wb_rw", bus.wb_RegWrite, rw_tbl[k-2]);
    end
    drain();

    // Load-use on rs1 and stall length
    step(1'b1, 1'b1, T_LD, 5'd0, 5'd0, 5'd5, 1'b0);
    n = 0; guard = 0;
    do begin
      step(1'b1, 1'b1, T_R, 5'd5, 5'd0, 5'd6, 1'b0);
      if (obs_stall) n++;
      guard++;
    end while (obs_stall && guard < 10);
    exp_n = FWD ? LUS : ((LUS > 2) ? LUS : 2);
    check("lu_stall_cycles", n, exp_n);
    check("lu_add_enters", bus.ex_rd, 5'd6);
    drain();

    // Same pair with rd=0 never stalls
    step(1'b1, 1'b1, T_LD, 5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b1, T_R, 5'd0, 5'd0, 5'd6, 1'b0);
    check("lu_rd0_stall", obs_stall, 1'b0);
    drain();

    // Redirect in the second stall cycle
    step(1'b1, 1'b1, T_LD, 5'd0, 5'd0, 5'd5, 1'b0);
    step(1'b1, 1'b1, T_R, 5'd5, 5'd0, 5'd6, 1'b0);
    check("fl_first_stall", obs_stall, 1'b1);
    step(1'b1, 1'b1, T_R, 5'd5, 5'd0, 5'd6, 1'b1);
    check("fl_stall_off", obs_stall, 1'b0);
    check("fl_flush_on", obs_flush, 1'b1);
    step(1'b1, 1'b1, T_R, 5'd5, 5'd0, 5'd6, 1'b0);
    check("fl_back_run", obs_stall, 1'b0);
    drain();

    // Illegal opcode with and without id_valid
    step(1'b1, 1'b1, 7'b1111111, 5'd0, 5'd0, 5'd7, 1'b0);
    check("ill_pulse", bus.IllegalInstr, 1'b1);
    check("ill_ex_zero", {bus.ex_RegWrite, bus.ex_MemRead, bus.ex_MemWrite, bus.ex_MemtoReg,
                          bus.ex_ALUSrc, bus.ex_Branch, bus.ex_Jump, bus.ex_PCSource, bus.ex_ALUOp}, 32'd0);
    step(1'b1, 1'b0, T_R, 5'd0, 5'd0, 5'd0, 1'b0);
    check("ill_one_cycle", bus.IllegalInstr, 1'b0);
    step(1'b1, 1'b0, 7'b1111111, 5'd0, 5'd0, 5'd7, 1'b0);
    check("ill_invalid", bus.IllegalInstr, 1'b0);
    drain();

    // ALU producer followed by consumer on rs2
    step(1'b1, 1'b1, T_R, 5'd0, 5'd0, 5'd3, 1'b0);
    n = 0; guard = 0;
    do begin
      step(1'b1, 1'b1, T_R, 5'd0, 5'd3, 5'd4, 1'b0);
      if (obs_stall) n++;
      guard++;
    end while (obs_stall && guard < 10);
`ifdef CTRL_FWD_EN
    check("raw_fwd_b", bus.ForwardB, 2'b10);
    check("raw_no_stall", n, 0);
`else
    check("raw_stall_cycles", n, 2);
`endif
    check("raw_sub_enters", bus.ex_rd, 5'd4);
    drain();

    // Randomized traffic with occasional resets and redirects
    for (int i = 0; i < 400; i++) begin : rnd
      logic [6:0] op;
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : op_tbl[$urandom_range(0, 7)];
      step($urandom_range(0, 49) != 0, $urandom_range(0, 6) != 0, op,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
